// File: rtl/bsg_link_echo_responder.sv
// rtl/bsg_link_echo_responder.sv - 2-entry echo buffer between link downstream and upstream cores
// Define BSG_LINK_ECHO_RESPONDER_CHECK_EN to build the incrementing-sequence checker; otherwise error_o is 0.
module bsg_link_echo_responder #(
   parameter int width_p = 32
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               en_i,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   output logic               yumi_o,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               ready_and_i,
   output logic               error_o,
   output logic [31:0]        received_o,
   output logic [31:0]        sent_o
);

   typedef enum logic [1:0] {EMPTY, ONE, TWO} fifo_state_e;

   fifo_state_e        state_r, state_n;
   logic [width_p-1:0] head_r, tail_r;
   logic               enq, deq;
   logic               head_from_in, head_from_tail, tail_from_in;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state_r <= EMPTY;
      else         state_r <= state_n;
   end

   // Acceptance depends only on registered occupancy, never on ready_and_i.
   // It is also held off during reset so no packet is dequeued and then lost.
   always_comb begin
      state_n        = state_r;
      v_o            = 1'b0;
      yumi_o         = 1'b0;
      enq            = 1'b0;
      deq            = 1'b0;
      head_from_in   = 1'b0;
      head_from_tail = 1'b0;
      tail_from_in   = 1'b0;

      v_o    = (state_r != EMPTY);
      yumi_o = v_i & en_i & ~reset_i & (state_r != TWO);
      enq    = yumi_o;
      deq    = v_o & ready_and_i;

      case (state_r)
         EMPTY: begin
            if (enq) begin
               state_n      = ONE;
               head_from_in = 1'b1;
            end
         end
         ONE: begin
            case ({enq, deq})
               2'b11: head_from_in = 1'b1;
               2'b10: begin
                  state_n      = TWO;
                  tail_from_in = 1'b1;
               end
               2'b01: state_n = EMPTY;
               default: ;
            endcase
         end
         TWO: begin
            if (deq) begin
               state_n        = ONE;
               head_from_tail = 1'b1;
            end
         end
         default: state_n = EMPTY;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         head_r <= '0;
         tail_r <= '0;
      end else begin
         if (head_from_in)        head_r <= data_i;
         else if (head_from_tail) head_r <= tail_r;
         if (tail_from_in)        tail_r <= data_i;
      end
   end

   assign data_o = head_r;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         received_o <= 32'd0;
         sent_o     <= 32'd0;
      end else begin
         if (enq) received_o <= received_o + 32'd1;
         if (deq) sent_o     <= sent_o + 32'd1;
      end
   end

`ifdef BSG_LINK_ECHO_RESPONDER_CHECK_EN
   typedef enum logic [1:0] {ALIGN, TRACK, FAIL} chk_state_e;

   chk_state_e         chk_r, chk_n;
   logic [width_p-1:0] expected_r, expected_n;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         chk_r      <= ALIGN;
         expected_r <= '0;
      end else begin
         chk_r      <= chk_n;
         expected_r <= expected_n;
      end
   end

   // The first accepted value seeds the sequence; FAIL is held until reset.
   always_comb begin
      chk_n      = chk_r;
      expected_n = expected_r;
      case (chk_r)
         ALIGN: begin
            if (enq) begin
               chk_n      = TRACK;
               expected_n = data_i + width_p'(1);
            end
         end
         TRACK: begin
            if (enq) begin
               if (data_i == expected_r) expected_n = data_i + width_p'(1);
               else                      chk_n      = FAIL;
            end
         end
         default: ;
      endcase
   end

   assign error_o = (chk_r == FAIL);
`else
   assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_link_echo_responder.sv
// tb/tb_bsg_link_echo_responder.sv - self-checking bench for bsg_link_echo_responder
// Scoreboard follows BSG_LINK_ECHO_RESPONDER_CHECK_EN to decide whether error_o may assert.
module tb_bsg_link_echo_responder;

   logic        clk = 1'b0;
   logic        reset_i = 1'b1;
   logic        en_i = 1'b0;
   logic        v_i = 1'b0;
   logic [31:0] data_i = '0;
   logic        ready_and_i = 1'b0;

   logic        yumi_o, v_o, error_o;
   logic [31:0] data_o, received_o, sent_o;

   logic [7:0]  data8_i;
   logic        yumi8_o, v8_o, error8_o;
   logic [7:0]  data8_o;
   logic [31:0] received8_o, sent8_o;

   assign data8_i = data_i[7:0];

   always #5 clk = ~clk;

`ifdef BSG_LINK_ECHO_RESPONDER_CHECK_EN
   localparam bit check_en = 1'b1;
`else
   localparam bit check_en = 1'b0;
`endif

   bsg_link_echo_responder #(.width_p(32)) dut (
      .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .v_i(v_i), .data_i(data_i),
      .yumi_o(yumi_o), .v_o(v_o), .data_o(data_o), .ready_and_i(ready_and_i),
      .error_o(error_o), .received_o(received_o), .sent_o(sent_o)
   );

   bsg_link_echo_responder #(.width_p(8)) dut8 (
      .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .v_i(v_i), .data_i(data8_i),
      .yumi_o(yumi8_o), .v_o(v8_o), .data_o(data8_o), .ready_and_i(ready_and_i),
      .error_o(error8_o), .received_o(received8_o), .sent_o(sent8_o)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: a bounded queue of accepted packets plus running totals.
   logic [31:0] q[$];
   logic [31:0] rcv_m, snt_m, prev_m;
   bit          err_m, have_prev;

   // Checks the 32-bit DUT every negedge, then advances the model across the
   // coming posedge (inputs only change just after posedges).
   always @(negedge clk) begin
      bit acc, xfer;
      if (reset_i) begin
         q.delete();
         rcv_m = '0; snt_m = '0; err_m = 1'b0; have_prev = 1'b0; prev_m = '0;
      end else begin
         checks++;
         if (v_o !== (q.size() > 0)) begin
            errors++; $display("FAIL mon_v_o: got %0b expected %0b at %0t", v_o, q.size() > 0, $time);
         end
         if (q.size() > 0) begin
            checks++;
            if (data_o !== q[0]) begin
               errors++; $display("FAIL mon_data_o: got %0h expected %0h at %0t", data_o, q[0], $time);
            end
         end
         checks++;
         if (yumi_o !== (v_i & en_i & (q.size() < 2))) begin
            errors++; $display("FAIL mon_yumi_o: got %0b expected %0b at %0t", yumi_o, v_i & en_i & (q.size() < 2), $time);
         end
         checks++;
         if (received_o !== rcv_m) begin
            errors++; $display("FAIL mon_received_o: got %0d expected %0d at %0t", received_o, rcv_m, $time);
         end
         checks++;
         if (sent_o !== snt_m) begin
            errors++; $display("FAIL mon_sent_o: got %0d expected %0d at %0t", sent_o, snt_m, $time);
         end
         checks++;
         if (error_o !== (check_en & err_m)) begin
            errors++; $display("FAIL mon_error_o: got %0b expected %0b at %0t", error_o, check_en & err_m, $time);
         end
         checks++;
         if ((received_o - sent_o) > 32'd2) begin
            errors++; $display("FAIL mon_count_gap: received %0d sent %0d at %0t", received_o, sent_o, $time);
         end

         acc  = v_i & en_i & (q.size() < 2);
         xfer = (q.size() > 0) & ready_and_i;
         if (xfer) begin
            void'(q.pop_front());
            snt_m = snt_m + 32'd1;
         end
         if (acc) begin
            if (have_prev && data_i != prev_m + 32'd1) err_m = 1'b1;
            have_prev = 1'b1;
            prev_m    = data_i;
            q.push_back(data_i);
            rcv_m = rcv_m + 32'd1;
         end
      end
   end

   task automatic drive(input logic v, input logic en, input logic rdy, input logic [31:0] d);
      @(posedge clk); #1;
      v_i = v; en_i = en; ready_and_i = rdy; data_i = d;
   endtask

   task automatic reset_dut();
      @(posedge clk); #1;
      reset_i = 1'b1; v_i = 1'b0; en_i = 1'b0; ready_and_i = 1'b0; data_i = '0;
      @(negedge clk);
      @(posedge clk); #1;
      reset_i = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL reset_v_o: got %0b expected 0", v_o); end
      checks++; if (yumi_o !== 1'b0) begin errors++; $display("FAIL reset_yumi_o: got %0b expected 0", yumi_o); end
      checks++; if (data_o !== 32'd0) begin errors++; $display("FAIL reset_data_o: got %0h expected 0", data_o); end
      checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL reset_error_o: got %0b expected 0", error_o); end
      checks++; if (received_o !== 32'd0) begin errors++; $display("FAIL reset_received_o: got %0d expected 0", received_o); end
      checks++; if (sent_o !== 32'd0) begin errors++; $display("FAIL reset_sent_o: got %0d expected 0", sent_o); end
      checks++; if (v8_o !== 1'b0) begin errors++; $display("FAIL reset_v8_o: got %0b expected 0", v8_o); end
      @(posedge clk); #1;
      reset_i = 1'b0;
   endtask

   task automatic test_stream();
      reset_dut();
      for (int i = 0; i < 100; i++) drive(1'b1, 1'b1, 1'b1, 32'(i));
      drive(1'b0, 1'b0, 1'b1, 32'd0);
      repeat (3) @(negedge clk);
      checks++; if (received_o !== 32'd100) begin errors++; $display("FAIL stream_received: got %0d expected 100", received_o); end
      checks++; if (sent_o !== 32'd100) begin errors++; $display("FAIL stream_sent: got %0d expected 100", sent_o); end
      checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL stream_error: got %0b expected 0", error_o); end
   endtask

   task automatic test_backpressure();
      int          pulses = 0;
      logic [31:0] nxt = '0;
      bit          took;
      reset_dut();
      drive(1'b1, 1'b1, 1'b0, 32'd0);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk); took = yumi_o; if (took) pulses++;
         @(posedge clk); #1;
         if (took) begin nxt = nxt + 32'd1; data_i = nxt; end
      end
      @(negedge clk);
      checks++; if (pulses != 2) begin errors++; $display("FAIL bp_yumi_pulses: got %0d expected 2", pulses); end
      checks++; if (v_o !== 1'b1) begin errors++; $display("FAIL bp_v_o: got %0b expected 1", v_o); end
      checks++; if (data_o !== 32'd0) begin errors++; $display("FAIL bp_head: got %0h expected 0", data_o); end
      checks++; if (yumi_o !== 1'b0) begin errors++; $display("FAIL bp_yumi_full: got %0b expected 0", yumi_o); end
      @(posedge clk); #1;
      ready_and_i = 1'b1;
      @(negedge clk);
      checks++; if (yumi_o !== 1'b0) begin errors++; $display("FAIL bp_yumi_before_deq: got %0b expected 0", yumi_o); end
      took = 1'b0;
      @(posedge clk); #1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk); took = yumi_o;
         checks++; if (data_o !== 32'(k)) begin errors++; $display("FAIL bp_drain_data: got %0h expected %0h", data_o, k); end
         checks++; if (yumi_o !== 1'b1) begin errors++; $display("FAIL bp_yumi_resume: got %0b expected 1", yumi_o); end
         @(posedge clk); #1;
         if (took) begin nxt = nxt + 32'd1; data_i = nxt; end
      end
      drive(1'b0, 1'b0, 1'b1, 32'd0);
      repeat (4) @(posedge clk);
   endtask

   task automatic test_error();
      logic [31:0] vals[5] = '{32'd5, 32'd6, 32'd7, 32'd9, 32'd10};
      reset_dut();
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         v_i = 1'b1; en_i = 1'b1; ready_and_i = 1'b1; data_i = vals[k];
         @(negedge clk);
         checks++;
         if (error_o !== ((k >= 4) ? check_en : 1'b0)) begin
            errors++; $display("FAIL err_timing: step %0d got %0b expected %0b", k, error_o, (k >= 4) ? check_en : 1'b0);
         end
      end
      drive(1'b0, 1'b0, 1'b1, 32'd0);
      repeat (3) @(negedge clk);
      checks++; if (error_o !== check_en) begin errors++; $display("FAIL err_sticky: got %0b expected %0b", error_o, check_en); end
      checks++; if (sent_o !== 32'd5) begin errors++; $display("FAIL err_sent: got %0d expected 5", sent_o); end
      checks++; if (received_o !== 32'd5) begin errors++; $display("FAIL err_received: got %0d expected 5", received_o); end
   endtask

   task automatic test_wrap8();
      logic [7:0] vals[4] = '{8'd254, 8'd255, 8'd0, 8'd1};
      reset_dut();
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         v_i = 1'b1; en_i = 1'b1; ready_and_i = 1'b1; data_i = {24'd0, vals[k]};
         @(negedge clk);
         if (k > 0) begin
            checks++;
            if (data8_o !== vals[k-1] || v8_o !== 1'b1) begin
               errors++; $display("FAIL wrap8_echo: got v=%0b d=%0d expected v=1 d=%0d", v8_o, data8_o, vals[k-1]);
            end
         end
         checks++; if (error8_o !== 1'b0) begin errors++; $display("FAIL wrap8_error: got %0b expected 0", error8_o); end
      end
      drive(1'b0, 1'b0, 1'b1, 32'd0);
      @(negedge clk);
      checks++; if (data8_o !== 8'd1) begin errors++; $display("FAIL wrap8_last: got %0d expected 1", data8_o); end
      repeat (2) @(negedge clk);
      checks++; if (sent8_o !== 32'd4 || received8_o !== 32'd4) begin
         errors++; $display("FAIL wrap8_counts: got sent %0d received %0d expected 4 4", sent8_o, received8_o);
      end
      checks++; if (error8_o !== 1'b0) begin errors++; $display("FAIL wrap8_error_end: got %0b expected 0", error8_o); end
   endtask

   task automatic test_random_reset();
      reset_dut();
      for (int c = 0; c < 10000; c++) begin
         @(posedge clk); #1;
         v_i         = 1'($urandom_range(0, 1));
         en_i        = ($urandom_range(0, 3) != 0);
         ready_and_i = 1'($urandom_range(0, 1));
         data_i      = ($urandom_range(0, 7) == 0) ? $urandom : 32'(c);
      end
      drive(1'b1, 1'b1, 1'b0, 32'h55);
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (v_o !== 1'b1 || yumi_o !== 1'b0) begin
         errors++; $display("FAIL rand_full: got v_o=%0b yumi_o=%0b expected 1 0", v_o, yumi_o);
      end
      #2 reset_i = 1'b1;
      #1;
      checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL async_reset_v_o: got %0b expected 0", v_o); end
      checks++; if (yumi_o !== 1'b0) begin errors++; $display("FAIL async_reset_yumi_o: got %0b expected 0", yumi_o); end
      checks++; if (received_o !== 32'd0 || sent_o !== 32'd0) begin
         errors++; $display("FAIL async_reset_counts: got %0d %0d expected 0 0", received_o, sent_o);
      end
      checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL async_reset_error: got %0b expected 0", error_o); end
      v_i = 1'b0; en_i = 1'b0; ready_and_i = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      reset_i = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_error();
      test_wrap8();
      test_random_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
